// File: rtl/dmem_responder.sv
// dmem_responder: target end of the CPU data-memory path.
// A one-cycle request is captured in IDLE, held for WAIT_CYCLES wait states,
// performed against a word-organised RAM with byte-lane writes, and answered
// with a one-cycle ack plus read data and an error flag.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 2048,
  parameter int          ADDR_W      = 11,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        dmem_req,
  input  logic        dmem_w,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ack,
  output logic        dmem_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Size of the decoded window in bytes; anything at or beyond is an error.
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) * 32'd4;
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        w_q, w_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [31:0]       off_s;
  logic              req_err_s;
  logic [ADDR_W-1:0] idx_s;
  logic [31:0]       mem_rd_s;
  logic              mem_we_s;

  logic [31:0] mem [DEPTH_WORDS];

  // Address decode of the captured request: offset wraps below BASE_ADDR,
  // so a single unsigned compare covers both ends of the window.
  always_comb begin
    off_s     = addr_q - BASE_ADDR;
    req_err_s = (addr_q[1:0] != 2'b00) || (off_s >= RAM_BYTES);
    idx_s     = off_s[ADDR_W+1:2];
    mem_rd_s  = mem[idx_s];
  end

  // Next-state, capture, access and response logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_d      = w_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    mem_we_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dmem_req) begin
          w_d     = dmem_w;
          addr_d  = dmem_addr;
          wdata_d = dmem_wdata;
          be_d    = dmem_be;
          cnt_d   = WAIT_LD;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          if (req_err_s) begin
            rdata_d = 32'h0000_0000;
            err_d   = 1'b1;
          end else if (w_q) begin
            mem_we_s = 1'b1;
            err_d    = 1'b0;
          end else begin
            rdata_d = mem_rd_s;
            err_d   = 1'b0;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control and response registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      w_q     <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      be_q    <= 4'b0000;
      rdata_q <= 32'h0000_0000;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // RAM array: byte-lane write on the access edge; contents survive reset.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_s && be_q[i]) begin
        mem[idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign dmem_rdata = rdata_q;
  assign dmem_ack   = ack_q;
  assign dmem_err   = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=2 and 0) share one
// clock and reset. Expected {rdata, err} are computed from a reference memory
// when a request is driven, queued, and compared when ack appears.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk_in = 1'b0;
  logic        rst    = 1'b0;

  logic        req_a = 1'b0, w_a = 1'b0;
  logic [31:0] addr_a = 32'h0, wdata_a = 32'h0, rdata_a;
  logic [3:0]  be_a = 4'h0;
  logic        ack_a, err_a, busy_a;

  logic        req_b = 1'b0, w_b = 1'b0;
  logic [31:0] addr_b = 32'h0, wdata_b = 32'h0, rdata_b;
  logic [3:0]  be_b = 4'h0;
  logic        ack_b, err_b, busy_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_a [int];
  logic [31:0] mdl_b [int];
  logic [31:0] last_rd [2];
  logic [32:0] exp_q_a [$];
  logic [32:0] exp_q_b [$];

  always #5 clk_in = ~clk_in;

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(2048), .ADDR_W(11), .WAIT_CYCLES(2)) dut_a (
    .clk_in(clk_in), .rst(rst), .dmem_req(req_a), .dmem_w(w_a), .dmem_addr(addr_a),
    .dmem_wdata(wdata_a), .dmem_be(be_a), .dmem_rdata(rdata_a), .dmem_ack(ack_a),
    .dmem_err(err_a), .busy(busy_a)
  );

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(2048), .ADDR_W(11), .WAIT_CYCLES(0)) dut_b (
    .clk_in(clk_in), .rst(rst), .dmem_req(req_b), .dmem_w(w_b), .dmem_addr(addr_b),
    .dmem_wdata(wdata_b), .dmem_be(be_b), .dmem_rdata(rdata_b), .dmem_ack(ack_b),
    .dmem_err(err_b), .busy(busy_b)
  );

  // Reference model: update model memory and queue the expected response.
  function automatic void sb_push(input bit inst, input bit w, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] off, cur, exp_rd;
    bit          err;
    int          idx;
    off = addr - BASE;
    err = (addr[1:0] != 2'b00) || (off >= 32'h0000_2000);
    idx = int'(off[12:2]);
    if (inst == 1'b0) cur = mdl_a.exists(idx) ? mdl_a[idx] : 32'hxxxx_xxxx;
    else              cur = mdl_b.exists(idx) ? mdl_b[idx] : 32'hxxxx_xxxx;
    if (err) begin
      exp_rd = 32'h0;
    end else if (w) begin
      for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = wdata[8*i +: 8];
      if (inst == 1'b0) mdl_a[idx] = cur; else mdl_b[idx] = cur;
      exp_rd = last_rd[inst];
    end else begin
      exp_rd = cur;
    end
    last_rd[inst] = exp_rd;
    if (inst == 1'b0) exp_q_a.push_back({exp_rd, err});
    else              exp_q_b.push_back({exp_rd, err});
  endfunction

  // Scoreboard for instance A: every ack must match the oldest expectation.
  always @(negedge clk_in) begin
    if (ack_a === 1'b1) begin
      checks++;
      if (exp_q_a.size() == 0) begin
        errors++;
        $display("FAIL sb_a_unexpected_ack: got ack with rdata=%h err=%b, required no ack", rdata_a, err_a);
      end else begin
        logic [32:0] e;
        e = exp_q_a.pop_front();
        if ({rdata_a, err_a} !== e) begin
          errors++;
          $display("FAIL sb_a_resp: got rdata=%h err=%b, required rdata=%h err=%b", rdata_a, err_a, e[32:1], e[0]);
        end
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk_in) begin
    if (ack_b === 1'b1) begin
      checks++;
      if (exp_q_b.size() == 0) begin
        errors++;
        $display("FAIL sb_b_unexpected_ack: got ack with rdata=%h err=%b, required no ack", rdata_b, err_b);
      end else begin
        logic [32:0] e;
        e = exp_q_b.pop_front();
        if ({rdata_b, err_b} !== e) begin
          errors++;
          $display("FAIL sb_b_resp: got rdata=%h err=%b, required rdata=%h err=%b", rdata_b, err_b, e[32:1], e[0]);
        end
      end
    end
  end

  // One complete request on an instance, checking busy and ack latency.
  task automatic issue(input bit inst, input bit w, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int n;
    int exp_lat;
    logic ack_s;
    exp_lat = (inst == 1'b0) ? 3 : 1;
    @(negedge clk_in);
    if (inst == 1'b0) begin
      req_a = 1'b1; w_a = w; addr_a = addr; wdata_a = wdata; be_a = be;
    end else begin
      req_b = 1'b1; w_b = w; addr_b = addr; wdata_b = wdata; be_b = be;
    end
    sb_push(inst, w, addr, wdata, be);
    @(posedge clk_in);
    #1;
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk_in);
    checks++;
    if (((inst == 1'b0) ? busy_a : busy_b) !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_capture: got busy=%b, required 1 (inst %0d)", (inst == 1'b0) ? busy_a : busy_b, inst);
    end
    n = 0;
    ack_s = (inst == 1'b0) ? ack_a : ack_b;
    while (ack_s !== 1'b1 && n < 40) begin
      @(posedge clk_in);
      @(negedge clk_in);
      n++;
      ack_s = (inst == 1'b0) ? ack_a : ack_b;
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL ack_latency: got %0d edges after capture, required %0d (inst %0d addr %h)", n, exp_lat, inst, addr);
    end
    @(posedge clk_in);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    checks++;
    if ({rdata_a, ack_a, err_a, busy_a} !== 35'h0 || {rdata_b, ack_b, err_b, busy_b} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h/%b/%b/%b b=%h/%b/%b/%b, required all 0",
               rdata_a, ack_a, err_a, busy_a, rdata_b, ack_b, err_b, busy_b);
    end
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    issue(1'b0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
  endtask

  task automatic test_byte_lanes();
    issue(1'b0, 1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF);
    issue(1'b0, 1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
    issue(1'b0, 1'b0, BASE + 32'h20, 32'h0, 4'hF);
    issue(1'b0, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'b0000);
    issue(1'b0, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
  endtask

  task automatic test_errors();
    issue(1'b0, 1'b1, BASE, 32'h5A5A_A5A5, 4'hF);
    issue(1'b0, 1'b0, 32'h1000_FFFC, 32'h0, 4'hF);
    issue(1'b0, 1'b1, BASE + 32'h2000, 32'hBAD0_BAD0, 4'hF);
    issue(1'b0, 1'b0, BASE + 32'h2, 32'h0, 4'hF);
    issue(1'b0, 1'b1, BASE + 32'h1, 32'h1234_5678, 4'hF);
    issue(1'b0, 1'b1, 32'h1000_FFFC, 32'h8765_4321, 4'hF);
    issue(1'b0, 1'b0, BASE, 32'h0, 4'h0);
  endtask

  task automatic test_busy_reject();
    @(negedge clk_in);
    req_a = 1'b1; w_a = 1'b0; addr_a = BASE + 32'h10; wdata_a = 32'h0; be_a = 4'hF;
    sb_push(1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    @(posedge clk_in);
    #1 req_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      checks++;
      if (busy_a !== 1'b1 || ack_a !== (c == 3)) begin
        errors++;
        $display("FAIL busy_reject_cycle%0d: got busy=%b ack=%b, required busy=1 ack=%b", c, busy_a, ack_a, (c == 3));
      end
      if (c == 0 || c == 3) begin
        req_a = 1'b1; w_a = 1'b1; addr_a = BASE; wdata_a = 32'h0BAD_F00D; be_a = 4'hF;
      end
      @(posedge clk_in);
      #1 req_a = 1'b0;
    end
    @(negedge clk_in);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle_after_resp: got busy=%b, required 0", busy_a);
    end
    req_a = 1'b1; w_a = 1'b0; addr_a = BASE; be_a = 4'hF;
    sb_push(1'b0, 1'b0, BASE, 32'h0, 4'hF);
    @(posedge clk_in);
    #1 req_a = 1'b0;
    @(negedge clk_in);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL busy_next_accept: got busy=%b, required 1", busy_a);
    end
    repeat (4) @(negedge clk_in);
    checks++;
    if (exp_q_a.size() != 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL busy_reject_drain: got %0d pending busy=%b, required 0 pending busy=0", exp_q_a.size(), busy_a);
    end
  endtask

  task automatic test_reset_mid_op();
    issue(1'b0, 1'b1, BASE + 32'h40, 32'h0, 4'hF);
    issue(1'b0, 1'b0, BASE + 32'h40, 32'h0, 4'hF);
    issue(1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    @(negedge clk_in);
    req_a = 1'b1; w_a = 1'b1; addr_a = BASE + 32'h40; wdata_a = 32'hCAFE_F00D; be_a = 4'hF;
    @(posedge clk_in);
    #1 req_a = 1'b0;
    @(posedge clk_in);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rdata_a, ack_a, err_a, busy_a} !== 35'h0) begin
      errors++;
      $display("FAIL reset_mid_op_outputs: got rdata=%h ack=%b err=%b busy=%b, required all 0", rdata_a, ack_a, err_a, busy_a);
    end
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    repeat (8) @(negedge clk_in);
    checks++;
    if (busy_a !== 1'b0 || exp_q_a.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_op_idle: got busy=%b pending=%0d, required 0/0", busy_a, exp_q_a.size());
    end
    issue(1'b0, 1'b0, BASE + 32'h40, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b1, BASE + 32'h1FFC, 32'h0F0F_0F0F, 4'hF);
    issue(1'b1, 1'b0, BASE + 32'h1FFC, 32'h0, 4'hF);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = BASE + 32'(4 * (k % 4)) + 32'h100;
      d = 32'hA5A5_0000 + 32'(k * 32'h0001_0101);
      @(negedge clk_in);
      req_b = 1'b1; w_b = (k < 4); addr_b = a; wdata_b = d; be_b = 4'hF;
      sb_push(1'b1, (k < 4), a, d, 4'hF);
      @(posedge clk_in);
      #1 req_b = 1'b0;
      @(posedge clk_in);
      @(posedge clk_in);
    end
    repeat (4) @(negedge clk_in);
    checks++;
    if (exp_q_b.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_drain: got %0d pending responses, required 0", exp_q_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_busy_reject();
    test_reset_mid_op();
    test_back_to_back();
    repeat (4) @(negedge clk_in);
    checks++;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d/%0d pending, required 0/0", exp_q_a.size(), exp_q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
